guard_err_resp: RTL and testbench

GUARD_ERR_RESP -- requirements
Module: guard_err_resp

---
 rtl/guard_err_resp.sv | 214 +++++++++++++++++++++
 tb/tb_guard_err_resp.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/guard_err_resp.sv
// guard_err_resp -- AXI4 slave isolation stage with a built-in error responder.
// While isolated, requests are blocked from the slave. Stale slave responses are
// drained, and the master gets SLVERR-style B/R responses from two small FSMs.
// Optional build macro GUARD_ERR_RESP_CNT_EN adds err_cnt_o. This is a saturating
// count of error responses delivered to the master.

package guard_err_resp_pkg;
  localparam int unsigned IdW   = 6;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned UserW = 1;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [2:0]       prot;
    logic [UserW-1:0] user;
  } ax_chan_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
    logic [UserW-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [1:0]       resp;
    logic [UserW-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
    logic [UserW-1:0] user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;
endpackage

module guard_err_resp #(
  parameter int unsigned AxiIdWidth = 6,
  parameter int unsigned DataWidth  = 32,
  parameter logic [1:0]  ErrResp    = 2'b10,
  parameter type         req_t      = guard_err_resp_pkg::axi_req_t,
  parameter type         rsp_t      = guard_err_resp_pkg::axi_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        isolate_i,
  input  req_t        req_i,
  output rsp_t        rsp_o,
  output req_t        req_o,
  input  rsp_t        rsp_i,
  output logic        isolated_o
`ifdef GUARD_ERR_RESP_CNT_EN
  ,
  output logic [15:0] err_cnt_o
`endif
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic                  isolated_q, isolated_d;
  logic [AxiIdWidth-1:0] w_id_q, w_id_d;
  logic [AxiIdWidth-1:0] r_id_q, r_id_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  r_last;

  // Write error FSM: accept one AW, swallow its W beats, answer with one error B.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    unique case (w_state_q)
      W_IDLE: if (isolated_q && req_i.aw_valid) begin
        w_id_d    = req_i.aw.id;
        w_state_d = W_DATA;
      end
      W_DATA: if (req_i.w_valid && req_i.w.last) w_state_d = W_RESP;
      W_RESP: if (req_i.b_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read error FSM: accept one AR, return len+1 zero-data error beats.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_last    = (r_cnt_q == r_len_q);
    unique case (r_state_q)
      R_IDLE: if (isolated_q && req_i.ar_valid) begin
        r_id_d    = req_i.ar.id;
        r_len_d   = req_i.ar.len;
        r_cnt_d   = '0;
        r_state_d = R_DATA;
      end
      R_DATA: if (req_i.r_ready) begin
        // The counter stops at len, so len=255 never wraps before the last beat.
        if (r_last) r_state_d = R_IDLE;
        else        r_cnt_d   = r_cnt_q + 8'd1;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Isolation is held until both FSMs are idle and no new transaction is being accepted.
  always_comb begin
    isolated_d = isolate_i ||
                 (isolated_q && !(w_state_q == W_IDLE && r_state_q == R_IDLE &&
                                  w_state_d == W_IDLE && r_state_d == R_IDLE));
  end

  // Datapath mux: transparent pass-through, or blocked requests plus FSM-driven responses.
  always_comb begin
    req_o = req_i;
    rsp_o = rsp_i;
    if (isolated_q) begin
      req_o.aw_valid = 1'b0;
      req_o.w_valid  = 1'b0;
      req_o.ar_valid = 1'b0;
      req_o.b_ready  = 1'b1;
      req_o.r_ready  = 1'b1;

      rsp_o          = '0;
      rsp_o.aw_ready = (w_state_q == W_IDLE);
      rsp_o.w_ready  = (w_state_q == W_DATA);
      rsp_o.b_valid  = (w_state_q == W_RESP);
      rsp_o.b.id     = w_id_q;
      rsp_o.b.resp   = ErrResp;
      rsp_o.ar_ready = (r_state_q == R_IDLE);
      rsp_o.r_valid  = (r_state_q == R_DATA);
      rsp_o.r.id     = r_id_q;
      rsp_o.r.data   = {DataWidth{1'b0}};
      rsp_o.r.resp   = ErrResp;
      rsp_o.r.last   = (r_state_q == R_DATA) && r_last;
    end
  end

  // State registers; reset abandons any burst in flight.
  always_ff @(posedge clk_i) begin
    // NOTE: registered state uses non-blocking assignments only.
    if (rst_i) begin
      isolated_q <= 1'b0;
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      w_id_q     <= '0;
      r_id_q     <= '0;
      r_len_q    <= '0;
      r_cnt_q    <= '0;
    end else begin
      isolated_q <= isolated_d;
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      w_id_q     <= w_id_d;
      r_id_q     <= r_id_d;
      r_len_q    <= r_len_d;
      r_cnt_q    <= r_cnt_d;
    end
  end

  assign isolated_o = isolated_q;

`ifdef GUARD_ERR_RESP_CNT_EN
  logic        b_err_hs;
  logic        r_err_end;
  logic [16:0] err_cnt_sum;
  logic [15:0] err_cnt_q;

  assign b_err_hs    = (w_state_q == W_RESP) && req_i.b_ready;
  assign r_err_end   = (r_state_q == R_DATA) && req_i.r_ready && r_last;
  assign err_cnt_sum = {1'b0, err_cnt_q} + 17'(b_err_hs) + 17'(r_err_end);

  // Saturating count of completed error B handshakes and error R bursts.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_sum[16] ? 16'hFFFF : err_cnt_sum[15:0];
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_guard_err_resp.sv
// Directed testbench for guard_err_resp: pass-through, isolated write/read error
// responses, concurrency, the 256-beat burst, late isolate release and mid-burst reset.
module tb_guard_err_resp;
  import guard_err_resp_pkg::*;

  logic     clk = 1'b0;
  logic     rst_i;
  logic     isolate_i;
  logic     isolated_o;
  axi_req_t req_i, req_o;
  axi_rsp_t rsp_i, rsp_o;
`ifdef GUARD_ERR_RESP_CNT_EN
  logic [15:0] err_cnt_o;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  guard_err_resp dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .isolate_i  (isolate_i),
    .req_i      (req_i),
    .rsp_o      (rsp_o),
    .req_o      (req_o),
    .rsp_i      (rsp_i),
    .isolated_o (isolated_o)
`ifdef GUARD_ERR_RESP_CNT_EN
    ,
    .err_cnt_o  (err_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated write: AW, `beats` W beats, then the error B.
  task automatic iso_write(input logic [5:0] id, input int beats);
    req_i.aw       = '0;
    req_i.aw.id    = id;
    req_i.aw.len   = 8'(beats - 1);
    req_i.aw_valid = 1'b1;
    #1;
    check("w_aw_ready", rsp_o.aw_ready, 1);
    check("w_aw_blocked", req_o.aw_valid, 0);
    check("w_aw_id_pass", req_o.aw.id, id);
    step();
    req_i.aw_valid = 1'b0;
    for (int i = 0; i < beats; i++) begin
      req_i.w.data  = 32'hA0 + i;
      req_i.w.last  = (i == beats - 1);
      req_i.w_valid = 1'b1;
      #1;
      check("w_aw_ready_busy", rsp_o.aw_ready, 0);
      check("w_w_ready", rsp_o.w_ready, 1);
      check("w_w_blocked", req_o.w_valid, 0);
      check("w_no_early_b", rsp_o.b_valid, 0);
      step();
    end
    req_i.w_valid = 1'b0;
    req_i.w.last  = 1'b0;
    req_i.b_ready = 1'b1;
    #1;
    check("w_b_valid", rsp_o.b_valid, 1);
    check("w_b_id", rsp_o.b.id, id);
    check("w_b_resp", rsp_o.b.resp, 2);
    check("w_b_user", rsp_o.b.user, 0);
    step();
    req_i.b_ready = 1'b0;
    #1;
    check("w_b_done", rsp_o.b_valid, 0);
  endtask

  // One isolated read: AR, then len+1 error beats with r_ready held high.
  task automatic iso_read(input logic [5:0] id, input int len);
    req_i.ar       = '0;
    req_i.ar.id    = id;
    req_i.ar.len   = 8'(len);
    req_i.ar_valid = 1'b1;
    #1;
    check("r_ar_ready", rsp_o.ar_ready, 1);
    check("r_ar_blocked", req_o.ar_valid, 0);
    check("r_rready_forced", req_o.r_ready, 1);
    step();
    req_i.ar_valid = 1'b0;
    req_i.r_ready  = 1'b1;
    for (int k = 0; k <= len; k++) begin
      #1;
      check("r_valid", rsp_o.r_valid, 1);
      check("r_id", rsp_o.r.id, id);
      check("r_data", rsp_o.r.data, 0);
      check("r_resp", rsp_o.r.resp, 2);
      check("r_last", rsp_o.r.last, (k == len) ? 1 : 0);
      step();
    end
    req_i.r_ready = 1'b0;
    #1;
    check("r_done", rsp_o.r_valid, 0);
  endtask

  initial begin
    int beats;

    // Reset wins over a simultaneous isolate request.
    req_i     = '0;
    rsp_i     = '0;
    rst_i     = 1'b1;
    isolate_i = 1'b1;
    step();
    step();
    check("rst_isolated", isolated_o, 0);
    check("rst_b_valid", rsp_o.b_valid, 0);
    check("rst_r_valid", rsp_o.r_valid, 0);
    check("rst_aw_pass", req_o.aw_valid, 0);
    rst_i     = 1'b0;
    isolate_i = 1'b0;
    step();
    check("idle_isolated", isolated_o, 0);

    // Transparent write: AW id=5 len=3, four W beats, slave's OKAY B.
    req_i.aw.id    = 6'd5;
    req_i.aw.len   = 8'd3;
    req_i.aw_valid = 1'b1;
    rsp_i.aw_ready = 1'b1;
    #1;
    check("pt_aw_valid", req_o.aw_valid, 1);
    check("pt_aw_id", req_o.aw.id, 5);
    check("pt_aw_len", req_o.aw.len, 3);
    check("pt_aw_ready", rsp_o.aw_ready, 1);
    step();
    req_i.aw_valid = 1'b0;
    rsp_i.aw_ready = 1'b0;
    rsp_i.w_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_i.w.data  = 32'h100 + i;
      req_i.w.last  = (i == 3);
      req_i.w_valid = 1'b1;
      #1;
      check("pt_w_valid", req_o.w_valid, 1);
      check("pt_w_data", req_o.w.data, 32'h100 + i);
      check("pt_w_last", req_o.w.last, (i == 3) ? 1 : 0);
      check("pt_w_ready", rsp_o.w_ready, 1);
      step();
    end
    req_i.w_valid = 1'b0;
    rsp_i.w_ready = 1'b0;
    rsp_i.b_valid = 1'b1;
    rsp_i.b.id    = 6'd5;
    rsp_i.b.resp  = 2'b00;
    req_i.b_ready = 1'b1;
    #1;
    check("pt_b_valid", rsp_o.b_valid, 1);
    check("pt_b_id", rsp_o.b.id, 5);
    check("pt_b_resp", rsp_o.b.resp, 0);
    check("pt_b_ready", req_o.b_ready, 1);
    step();
    req_i = '0;
    rsp_i = '0;

    // Isolation sets one cycle after isolate_i is sampled; junk slave responses are ignored.
    isolate_i     = 1'b1;
    rsp_i.b_valid = 1'b1;
    rsp_i.b.id    = 6'd9;
    rsp_i.r_valid = 1'b1;
    rsp_i.r.last  = 1'b1;
    #1;
    check("iso_not_yet", isolated_o, 0);
    step();
    check("iso_set", isolated_o, 1);
    check("iso_b_ignored", rsp_o.b_valid, 0);
    check("iso_r_ignored", rsp_o.r_valid, 0);
    check("iso_bready_forced", req_o.b_ready, 1);

    iso_write(6'd7, 2);
    iso_read(6'd3, 2);

    // Concurrent write (id=4) and read (id=6, len=0).
    req_i.aw.id    = 6'd4;
    req_i.aw_valid = 1'b1;
    req_i.ar.id    = 6'd6;
    req_i.ar.len   = 8'd0;
    req_i.ar_valid = 1'b1;
    #1;
    check("cc_aw_ready", rsp_o.aw_ready, 1);
    check("cc_ar_ready", rsp_o.ar_ready, 1);
    step();
    req_i.aw_valid = 1'b0;
    req_i.ar_valid = 1'b0;
    req_i.w.last   = 1'b1;
    req_i.w_valid  = 1'b1;
    req_i.r_ready  = 1'b1;
    #1;
    check("cc_w_ready", rsp_o.w_ready, 1);
    check("cc_r_valid", rsp_o.r_valid, 1);
    check("cc_r_id", rsp_o.r.id, 6);
    check("cc_r_last", rsp_o.r.last, 1);
    step();
    req_i.w_valid = 1'b0;
    req_i.w.last  = 1'b0;
    req_i.r_ready = 1'b0;
    req_i.b_ready = 1'b1;
    #1;
    check("cc_b_valid", rsp_o.b_valid, 1);
    check("cc_b_id", rsp_o.b.id, 4);
    check("cc_r_done", rsp_o.r_valid, 0);
    step();
    req_i.b_ready = 1'b0;

    // Maximum burst: len=255 gives 256 beats, last only on the final one.
    iso_read(6'd9, 255);

    // len=7 with toggling r_ready; isolate_i drops after two beats.
    req_i.ar       = '0;
    req_i.ar.id    = 6'd1;
    req_i.ar.len   = 8'd7;
    req_i.ar_valid = 1'b1;
    step();
    req_i.ar_valid = 1'b0;
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      req_i.r_ready = c[0];
      #1;
      check("tg_r_valid", rsp_o.r_valid, 1);
      check("tg_r_last", rsp_o.r.last, (beats == 7) ? 1 : 0);
      check("tg_isolated", isolated_o, 1);
      step();
      if (req_i.r_ready) beats++;
      if (beats == 2) isolate_i = 1'b0;
    end
    check("tg_beat_count", beats, 8);
    req_i.r_ready = 1'b0;
    #1;
    check("tg_idle_r_valid", rsp_o.r_valid, 0);
    check("tg_still_isolated", isolated_o, 1);
    step();
    check("tg_released", isolated_o, 0);
    check("tg_b_passthrough", rsp_o.b_valid, 1);
    rsp_i = '0;

    // Reset during beat 1 of a len=4 burst abandons it.
    isolate_i = 1'b1;
    step();
    req_i.ar       = '0;
    req_i.ar.id    = 6'd2;
    req_i.ar.len   = 8'd4;
    req_i.ar_valid = 1'b1;
    step();
    req_i.ar_valid = 1'b0;
    req_i.r_ready  = 1'b1;
    step();
    rst_i = 1'b1;
    #1;
    check("mr_beat1_valid", rsp_o.r_valid, 1);
    step();
    check("mr_r_valid", rsp_o.r_valid, 0);
    check("mr_isolated", isolated_o, 0);
    rst_i = 1'b0;
    step();
    check("mr_reisolated", isolated_o, 1);
    check("mr_no_resume", rsp_o.r_valid, 0);
    check("mr_ar_ready", rsp_o.ar_ready, 1);
    req_i.r_ready = 1'b0;

    // Three isolated writes and two isolated reads after reset.
    iso_write(6'd1, 1);
    iso_write(6'd2, 3);
    iso_write(6'd3, 1);
    iso_read(6'd4, 0);
    iso_read(6'd5, 1);
`ifdef GUARD_ERR_RESP_CNT_EN
    check("err_cnt", err_cnt_o, 5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
